// File: rtl/fifoc_cmd_pkg.sv
// Shared constants, state and error encodings for the FIFO C command-frame parser.
// Frame layout: HEAD0, HEAD1, nine payload bytes, then the XOR of those payload bytes.
package fifoc_cmd_pkg;

  localparam logic [7:0] HEAD0     = 8'h55;
  localparam logic [7:0] HEAD1     = 8'hAA;
  localparam int         FRAME_LEN = 12;
  localparam int         NUM_CMD   = 9;

  localparam int IDX_HEAD0 = 0;
  localparam int IDX_HEAD1 = 1;
  localparam int IDX_KDEV  = 2;
  localparam int IDX_SMPR  = 3;
  localparam int IDX_FILT  = 4;
  localparam int IDX_MIX0  = 5;
  localparam int IDX_MIX1  = 6;
  localparam int IDX_REG4  = 7;
  localparam int IDX_REG5  = 8;
  localparam int IDX_REG6  = 9;
  localparam int IDX_REG7  = 10;
  localparam int IDX_CHK   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_HEADER  = 2'd1,
    ERR_CHKSUM  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  function automatic logic [7:0] payload_xor(input frame_t f);
    logic [7:0] x;
    x = '0;
    for (int i = IDX_KDEV; i <= IDX_REG7; i++) x ^= f[i];
    return x;
  endfunction

endpackage

// File: rtl/fifoc_rd_if.sv
// FIFO C read side: issues up to FRAME_LEN reads, tracks the one-cycle read latency
// and counts stalled (empty) cycles so the parser can abandon a starved frame.
module fifoc_rd_if
  import fifoc_cmd_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       fifoc_empty,
  input  logic [7:0] fifoc_dout,
  output logic       fifoc_rd_en,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic [3:0] byte_idx,
  output logic       timeout
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [3:0]    issued;
  logic [3:0]    captured;
  logic          rd_vld;
  logic [TW-1:0] stall_cnt;
  logic          more;
  logic          stall;

  assign more        = (issued < 4'(FRAME_LEN));
  assign fifoc_rd_en = active && !fifoc_empty && more;
  assign stall       = active && fifoc_empty && more;
  assign timeout     = stall && (stall_cnt == TW'(TIMEOUT - 1));

  // dout is valid the cycle after the read strobe; captured is that byte's frame index
  assign byte_vld = rd_vld;
  assign byte_dat = fifoc_dout;
  assign byte_idx = captured;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued    <= '0;
      captured  <= '0;
      rd_vld    <= 1'b0;
      stall_cnt <= '0;
    end else if (!active) begin
      issued    <= '0;
      captured  <= '0;
      rd_vld    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      rd_vld <= fifoc_rd_en;
      if (fifoc_rd_en) issued <= issued + 4'd1;
      if (rd_vld) captured <= captured + 4'd1;
      if (fifoc_rd_en) stall_cnt <= '0;
      else if (stall)  stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifoc_cmd_parse.sv
// Parses one host command frame from FIFO C into the cmd_* registers; payload is
// committed atomically, and only when both header bytes and the XOR check are good.
module fifoc_cmd_parse
  import fifoc_cmd_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fs_fifoc2cs,
  output logic       fd_fifoc2cs,
  output logic       fifoc_rd_en,
  input  logic [7:0] fifoc_dout,
  input  logic       fifoc_empty,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] cmd_kdev,
  output logic [7:0] cmd_smpr,
  output logic [7:0] cmd_filt,
  output logic [7:0] cmd_mix0,
  output logic [7:0] cmd_mix1,
  output logic [7:0] cmd_reg4,
  output logic [7:0] cmd_reg5,
  output logic [7:0] cmd_reg6,
  output logic [7:0] cmd_reg7,
  output state_e     dbg_state
);

  // Handshake: fs is a level held by cs_cmd until it sees fd; fd is held in DONE until
  // fs drops. Dropping fs before DONE abandons the frame with no commit and no fd.

  state_e                      state_q, state_d;
  frame_t                      shadow_q;
  logic [NUM_CMD-1:0][7:0]     cmd_q;
  logic                        err_q;
  err_code_e                   code_q;
  logic                        rd_active;
  logic                        byte_vld;
  logic [7:0]                  byte_dat;
  logic [3:0]                  byte_idx;
  logic                        timeout;
  logic                        hdr_ok;
  logic                        chk_ok;
  logic                        last_byte;

  fifoc_rd_if #(.TIMEOUT(TIMEOUT)) u_rd_if (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (rd_active),
    .fifoc_empty (fifoc_empty),
    .fifoc_dout  (fifoc_dout),
    .fifoc_rd_en (fifoc_rd_en),
    .byte_vld    (byte_vld),
    .byte_dat    (byte_dat),
    .byte_idx    (byte_idx),
    .timeout     (timeout)
  );

  assign hdr_ok    = (shadow_q[IDX_HEAD0] == HEAD0) && (shadow_q[IDX_HEAD1] == HEAD1);
  assign chk_ok    = (payload_xor(shadow_q) == shadow_q[IDX_CHK]);
  assign last_byte = byte_vld && (byte_idx == 4'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fs_fifoc2cs) state_d = ST_READ;
      ST_READ: begin
        if (!fs_fifoc2cs)   state_d = ST_IDLE;
        else if (timeout)   state_d = ST_DONE;
        else if (last_byte) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = fs_fifoc2cs ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!fs_fifoc2cs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fd_fifoc2cs = (state_q == ST_DONE);
    rd_active   = (state_q == ST_READ);
    dbg_state   = state_q;
  end

  // Shadow capture, error flags and the atomic commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cmd_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      if (state_q == ST_READ && byte_vld) begin
        for (int i = 0; i < FRAME_LEN; i++)
          if (byte_idx == 4'(i)) shadow_q[i] <= byte_dat;
      end
      if (state_q == ST_IDLE && fs_fifoc2cs) begin
        err_q  <= 1'b0;
        code_q <= ERR_NONE;
      end
      if (state_q == ST_READ && fs_fifoc2cs && timeout) begin
        err_q  <= 1'b1;
        code_q <= ERR_TIMEOUT;
      end
      if (state_q == ST_CHECK && fs_fifoc2cs) begin
        if (!hdr_ok) begin
          err_q  <= 1'b1;
          code_q <= ERR_HEADER;
        end else if (!chk_ok) begin
          err_q  <= 1'b1;
          code_q <= ERR_CHKSUM;
        end else begin
          for (int i = 0; i < NUM_CMD; i++) cmd_q[i] <= shadow_q[IDX_KDEV + i];
        end
      end
    end
  end

  assign err      = err_q;
  assign err_code = code_q;
  assign cmd_kdev = cmd_q[IDX_KDEV - IDX_KDEV];
  assign cmd_smpr = cmd_q[IDX_SMPR - IDX_KDEV];
  assign cmd_filt = cmd_q[IDX_FILT - IDX_KDEV];
  assign cmd_mix0 = cmd_q[IDX_MIX0 - IDX_KDEV];
  assign cmd_mix1 = cmd_q[IDX_MIX1 - IDX_KDEV];
  assign cmd_reg4 = cmd_q[IDX_REG4 - IDX_KDEV];
  assign cmd_reg5 = cmd_q[IDX_REG5 - IDX_KDEV];
  assign cmd_reg6 = cmd_q[IDX_REG6 - IDX_KDEV];
  assign cmd_reg7 = cmd_q[IDX_REG7 - IDX_KDEV];

endmodule

// File: tb/tb_fifoc_cmd_parse.sv
// Directed bench for fifoc_cmd_parse: a small FIFO model feeds frames, each check is an
// immediate assertion against hand-computed values.
module tb_fifoc_cmd_parse;
  import fifoc_cmd_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       fs_fifoc2cs;
  logic       fd_fifoc2cs;
  logic       fifoc_rd_en;
  logic [7:0] fifoc_dout;
  logic       fifoc_empty;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1;
  logic [7:0] cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
  state_e     dbg_state;
  logic [7:0] cmd_v [9];

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model
  logic [7:0] mem [64];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic       flush;
  int         rd_total;
  int         viol;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifoc_cmd_parse #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fs_fifoc2cs (fs_fifoc2cs),
    .fd_fifoc2cs (fd_fifoc2cs),
    .fifoc_rd_en (fifoc_rd_en),
    .fifoc_dout  (fifoc_dout),
    .fifoc_empty (fifoc_empty),
    .err         (err),
    .err_code    (err_code),
    .cmd_kdev    (cmd_kdev),
    .cmd_smpr    (cmd_smpr),
    .cmd_filt    (cmd_filt),
    .cmd_mix0    (cmd_mix0),
    .cmd_mix1    (cmd_mix1),
    .cmd_reg4    (cmd_reg4),
    .cmd_reg5    (cmd_reg5),
    .cmd_reg6    (cmd_reg6),
    .cmd_reg7    (cmd_reg7),
    .dbg_state   (dbg_state)
  );

  always_comb begin
    cmd_v[0] = cmd_kdev; cmd_v[1] = cmd_smpr; cmd_v[2] = cmd_filt;
    cmd_v[3] = cmd_mix0; cmd_v[4] = cmd_mix1; cmd_v[5] = cmd_reg4;
    cmd_v[6] = cmd_reg5; cmd_v[7] = cmd_reg6; cmd_v[8] = cmd_reg7;
  end

  assign fifoc_empty = (rd_ptr == wr_ptr);

  initial begin
    rd_ptr     = '0;
    fifoc_dout = '0;
    rd_total   = 0;
    viol       = 0;
  end

  always @(posedge clk) begin
    if (fifoc_rd_en && fifoc_empty) viol <= viol + 1;
    if (fifoc_rd_en) rd_total <= rd_total + 1;
    if (flush) rd_ptr <= wr_ptr;
    else if (fifoc_rd_en && !fifoc_empty) begin
      fifoc_dout <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 6'd1;
    end
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmds(input string tag, input logic [7:0] first, input logic [7:0] step);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_cmd%0d", tag, i), 32'(cmd_v[i]), 32'(8'(first + step * 8'(i))));
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 6'd1;
  endtask

  task automatic load_frame(input logic [7:0] h0, input logic [7:0] first,
                            input logic [7:0] chk, input int n_bytes);
    logic [7:0] fr [12];
    fr[0] = h0;
    fr[1] = 8'hAA;
    for (int i = 0; i < 9; i++) fr[2 + i] = first + 8'(i);
    fr[11] = chk;
    for (int i = 0; i < n_bytes; i++) push(fr[i]);
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  // Raises fs and counts cycles from the edge that samples it until fd is seen.
  task automatic start_and_wait(input int limit, output int cyc);
    @(negedge clk);
    fs_fifoc2cs = 1'b1;
    cyc = 0;
    @(posedge clk);
    while (cyc < limit) begin
      @(negedge clk);
      if (fd_fifoc2cs) break;
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic end_handshake(input string tag);
    @(negedge clk);
    fs_fifoc2cs = 1'b0;
    @(negedge clk);
    check({tag, "_fd_low"}, 32'(fd_fifoc2cs), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int cyc;
    int rd_before;
    logic fd_seen;

    rst_n       = 1'b0;
    fs_fifoc2cs = 1'b0;
    flush       = 1'b0;
    wr_ptr      = '0;
    repeat (3) @(negedge clk);
    check("rst_fd", 32'(fd_fifoc2cs), 32'd0);
    check("rst_rd_en", 32'(fifoc_rd_en), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_cmds("rst", 8'h00, 8'h00);
    rst_n = 1'b1;

    // 1: good frame, latency 14, fd held while fs high
    load_frame(8'h55, 8'h01, 8'h01, 12);
    start_and_wait(60, cyc);
    check("t1_fd", 32'(fd_fifoc2cs), 32'd1);
    check("t1_latency", 32'(cyc), 32'd14);
    check("t1_err", 32'(err), 32'd0);
    check("t1_code", 32'(err_code), 32'd0);
    check_cmds("t1", 8'h01, 8'h01);
    repeat (3) @(negedge clk);
    check("t1_fd_hold", 32'(fd_fifoc2cs), 32'd1);
    check("t1_done_hold", 32'(dbg_state), 32'(ST_DONE));
    end_handshake("t1");

    // 2: checksum error, no commit, frame drained
    load_frame(8'h55, 8'h11, 8'h00, 12);
    start_and_wait(60, cyc);
    check("t2_fd", 32'(fd_fifoc2cs), 32'd1);
    check("t2_latency", 32'(cyc), 32'd14);
    check("t2_err", 32'(err), 32'd1);
    check("t2_code", 32'(err_code), 32'd2);
    check("t2_empty", 32'(fifoc_empty), 32'd1);
    check_cmds("t2", 8'h01, 8'h01);
    end_handshake("t2");

    // 3: header error drains all 12, then a good frame parses
    load_frame(8'h54, 8'h21, 8'h21, 12);
    start_and_wait(60, cyc);
    check("t3_fd", 32'(fd_fifoc2cs), 32'd1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_code", 32'(err_code), 32'd1);
    check("t3_empty", 32'(fifoc_empty), 32'd1);
    check_cmds("t3", 8'h01, 8'h01);
    end_handshake("t3");
    load_frame(8'h55, 8'h31, 8'h31, 12);
    start_and_wait(60, cyc);
    check("t3b_fd", 32'(fd_fifoc2cs), 32'd1);
    check("t3b_err", 32'(err), 32'd0);
    check("t3b_code", 32'(err_code), 32'd0);
    check_cmds("t3b", 8'h31, 8'h01);
    end_handshake("t3b");

    // 4: only 5 bytes -> timeout after 16 stalled cycles
    load_frame(8'h55, 8'h41, 8'h00, 5);
    rd_before = rd_total;
    start_and_wait(80, cyc);
    check("t4_fd", 32'(fd_fifoc2cs), 32'd1);
    check("t4_latency", 32'(cyc), 32'd21);
    check("t4_reads", 32'(rd_total - rd_before), 32'd5);
    check("t4_err", 32'(err), 32'd1);
    check("t4_code", 32'(err_code), 32'd3);
    check_cmds("t4", 8'h31, 8'h01);
    end_handshake("t4");

    // 5: fs dropped mid-frame, then reset mid-frame
    load_frame(8'h55, 8'h51, 8'h51, 12);
    @(negedge clk);
    fs_fifoc2cs = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    fs_fifoc2cs = 1'b0;
    @(negedge clk);
    check("t5_abort_idle", 32'(dbg_state), 32'(ST_IDLE));
    fd_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      fd_seen = fd_seen | fd_fifoc2cs;
    end
    check("t5_no_fd", 32'(fd_seen), 32'd0);
    check_cmds("t5", 8'h31, 8'h01);
    do_flush();
    load_frame(8'h55, 8'h61, 8'h61, 12);
    @(negedge clk);
    fs_fifoc2cs = 1'b1;
    repeat (8) @(negedge clk);
    rst_n       = 1'b0;
    fs_fifoc2cs = 1'b0;
    #1;
    check("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_rst_rd_en", 32'(fifoc_rd_en), 32'd0);
    check_cmds("t5_rst", 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    do_flush();

    // 6: slow trickle feed, two back-to-back handshakes
    viol = 0;
    fork
      begin
        logic [7:0] bytes [24];
        bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[11] = 8'h71;
        bytes[12] = 8'h55; bytes[13] = 8'hAA; bytes[23] = 8'h81;
        for (int i = 0; i < 9; i++) begin
          bytes[2 + i]  = 8'h71 + 8'(i);
          bytes[14 + i] = 8'h81 + 8'(i);
        end
        for (int i = 0; i < 24; i++) begin
          push(bytes[i]);
          repeat (2) @(negedge clk);
        end
      end
      begin
        start_and_wait(200, cyc);
        check("t6a_fd", 32'(fd_fifoc2cs), 32'd1);
        check("t6a_err", 32'(err), 32'd0);
        check_cmds("t6a", 8'h71, 8'h01);
        end_handshake("t6a");
        start_and_wait(200, cyc);
        check("t6b_fd", 32'(fd_fifoc2cs), 32'd1);
        check("t6b_err", 32'(err), 32'd0);
        check_cmds("t6b", 8'h81, 8'h01);
        end_handshake("t6b");
      end
    join
    check("t6_rd_while_empty", 32'(viol), 32'd0);
    check("t6_empty", 32'(fifoc_empty), 32'd1);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
